// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache with a single outstanding miss.
// Defining ICACHE_PERF_EN adds the hit_cnt/miss_cnt performance counters.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic [31:0] if_inst,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_ready,
  input  logic [31:0] mc_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TW = 30 - INDEX_BITS;
  typedef enum logic {IDLE, MISS} state_t;
  state_t state_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0] tag_q [LINES];
  logic [31:0] data_q [LINES];
  logic mc_req_q;
  logic [31:0] mc_addr_q;
  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic [TW-1:0] tag;
  logic go, hit, fill, fwd, miss_start, unused_ok;
  assign idx = if_pc[INDEX_BITS+1:2];
  assign tag = if_pc[31:INDEX_BITS+2];
  assign fill_idx = mc_addr_q[INDEX_BITS+1:2];
  assign unused_ok = ^if_pc[1:0];
  // go gates every state change and every if_ready, so rst, rdy=0 and clear all suppress them
  assign go = rdy && !rst && !clear;
  assign hit = state_q == IDLE && if_valid && valid_q[idx] && tag_q[idx] == tag;
  assign fill = go && state_q == MISS && mc_ready;
  assign fwd = fill && if_valid && if_pc[31:2] == mc_addr_q[31:2];
  assign miss_start = go && state_q == IDLE && if_valid && !hit;
  assign if_ready = (go && hit) || fwd;
  assign if_inst = (state_q == MISS && mc_ready) ? mc_data : data_q[idx];
  assign mc_req = mc_req_q;
  assign mc_addr = mc_addr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      mc_req_q <= 1'b0;
      mc_addr_q <= '0;
    end else if (rdy) begin
      if (clear) begin
        state_q <= IDLE;
        mc_req_q <= 1'b0;
      end else if (miss_start) begin
        state_q <= MISS;
        mc_req_q <= 1'b1;
        mc_addr_q <= {if_pc[31:2], 2'b00};
      end else if (fill) begin
        state_q <= IDLE;
        mc_req_q <= 1'b0;
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_idx] <= mc_addr_q[31:INDEX_BITS+2];
      data_q[fill_idx] <= mc_data;
    end
  end
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= '0;
      miss_q <= '0;
    end else if (rdy) begin
      if (go && hit) hit_q <= hit_q + 32'd1;
      if (miss_start) miss_q <= miss_q + 32'd1;
    end
  end
  assign hit_cnt = hit_q;
  assign miss_cnt = miss_q;
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed test of icache fills, hits, conflicts, clear, stall and reset.
module tb_icache;
  logic clk = 1'b0;
  logic rst, rdy, clear, if_valid, mc_ready, if_ready, mc_req;
  logic [31:0] if_pc, mc_data, if_inst, mc_addr;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_valid(if_valid), .if_pc(if_pc), .if_ready(if_ready), .if_inst(if_inst),
    .mc_req(mc_req), .mc_addr(mc_addr), .mc_ready(mc_ready), .mc_data(mc_data)
`ifdef ICACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // drive fetch and memory inputs, then settle before sampling
  task automatic drive(input logic v, input logic [31:0] pc, input logic mr, input logic [31:0] md);
    if_valid = v;
    if_pc = pc;
    mc_ready = mr;
    mc_data = md;
    #1;
  endtask
  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    drive(1'b1, 32'h100, 1'b0, 32'h0);
    check("rst_if_ready", if_ready, 0);
    step;
    step;
    check("rst_mc_req", mc_req, 0);
    check("rst_mc_addr", mc_addr, 32'h0);
    check("rst_if_ready2", if_ready, 0);
    rst = 1'b0;
    drive(1'b1, 32'h102, 1'b0, 32'h0);
    check("cold_miss_rdy", if_ready, 0);
    step;
    check("cold_req", mc_req, 1);
    check("cold_addr", mc_addr, 32'h100);
    check("cold_wait_rdy", if_ready, 0);
    drive(1'b1, 32'h100, 1'b1, 32'h00A00093);
    check("fwd_rdy", if_ready, 1);
    check("fwd_inst", if_inst, 32'h00A00093);
    step;
    drive(1'b1, 32'h100, 1'b0, 32'h0);
    check("fill_req_low", mc_req, 0);
    check("hit_rdy", if_ready, 1);
    check("hit_inst", if_inst, 32'h00A00093);
    step;
    check("hit_req_low", mc_req, 0);
`ifdef ICACHE_PERF_EN
    check("perf_hit", hit_cnt, 1);
    check("perf_miss", miss_cnt, 1);
`endif
    drive(1'b1, 32'h200, 1'b0, 32'h0);
    check("conf_miss_rdy", if_ready, 0);
    step;
    check("conf_req", mc_req, 1);
    check("conf_addr", mc_addr, 32'h200);
    drive(1'b1, 32'h200, 1'b1, 32'h11111111);
    check("conf_fwd_rdy", if_ready, 1);
    check("conf_fwd_inst", if_inst, 32'h11111111);
    step;
    drive(1'b1, 32'h100, 1'b0, 32'h0);
    check("evicted_rdy", if_ready, 0);
    step;
    check("evicted_addr", mc_addr, 32'h100);
    drive(1'b1, 32'h500, 1'b0, 32'h0);
    step;
    check("addr_hold_pc", mc_addr, 32'h100);
    drive(1'b1, 32'h500, 1'b1, 32'h00A00093);
    check("fill_no_fwd", if_ready, 0);
    step;
    drive(1'b1, 32'h300, 1'b0, 32'h0);
    step;
    check("clr_req", mc_req, 1);
    check("clr_addr", mc_addr, 32'h300);
    clear = 1'b1;
    drive(1'b1, 32'h300, 1'b1, 32'h33333333);
    check("clr_if_ready", if_ready, 0);
    step;
    clear = 1'b0;
    drive(1'b0, 32'h300, 1'b1, 32'hDEADBEEF);
    check("clr_req_low", mc_req, 0);
    step;
    drive(1'b1, 32'h300, 1'b0, 32'h0);
    check("late_req_low", mc_req, 0);
    check("clr_nofill", if_ready, 0);
    step;
    check("refetch_req", mc_req, 1);
    check("refetch_addr", mc_addr, 32'h300);
    rdy = 1'b0;
    drive(1'b1, 32'h300, 1'b1, 32'h33333333);
    for (int i = 0; i < 5; i++) begin
      check("stall_if_ready", if_ready, 0);
      step;
      check("stall_req", mc_req, 1);
      check("stall_addr", mc_addr, 32'h300);
    end
    rdy = 1'b1;
    #1;
    check("stall_fwd_rdy", if_ready, 1);
    check("stall_fwd_inst", if_inst, 32'h33333333);
    step;
    drive(1'b1, 32'h300, 1'b0, 32'h0);
    check("stall_hit", if_ready, 1);
    check("stall_hit_inst", if_inst, 32'h33333333);
    drive(1'b1, 32'h100, 1'b0, 32'h0);
    step;
    drive(1'b1, 32'h100, 1'b1, 32'h00A00093);
    step;
    drive(1'b1, 32'h100, 1'b0, 32'h0);
    check("refill_hit", if_ready, 1);
    drive(1'b1, 32'h104, 1'b0, 32'h0);
    step;
    check("pre_rst_req", mc_req, 1);
    rst = 1'b1;
    drive(1'b1, 32'h104, 1'b1, 32'h44444444);
    check("rst_mid_if_ready", if_ready, 0);
    step;
    rst = 1'b0;
    drive(1'b1, 32'h100, 1'b0, 32'h0);
    check("post_rst_req", mc_req, 0);
    check("post_rst_addr", mc_addr, 32'h0);
    check("post_rst_miss", if_ready, 0);
`ifdef ICACHE_PERF_EN
    check("post_rst_hit_cnt", hit_cnt, 0);
    check("post_rst_miss_cnt", miss_cnt, 0);
`endif
    step;
    check("post_rst_req2", mc_req, 1);
    check("post_rst_addr2", mc_addr, 32'h100);
    drive(1'b1, 32'h104, 1'b0, 32'h0);
    check("rst_nofill_104", if_ready, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
